// File: rtl/cmd_pkg.sv
// Shared types and constants for the AT command sequencer and its testbench.
package cmd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_NUM,
    WAIT_NUM,
    RD_BYTE,
    WAIT_BYTE,
    SEND,
    GAP,
    DONE
  } seq_state_t;

  localparam logic [1:0] ERR_EMPTY = 2'b01;
  localparam logic [1:0] ERR_CLAMP = 2'b10;

  localparam logic [7:0] LF  = 8'h0A;
  localparam logic [7:0] PAD = 8'h00;

endpackage

// File: rtl/gap_timer.sv
// Load/count/expire down-counter that spaces commands apart; expired pulses once per load.
module gap_timer #(
  parameter int GAP_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic expired
);

  localparam int W = $clog2(GAP_CYCLES + 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      expired <= 1'b0;
    end else begin
      expired <= 1'b0;
      if (load) begin
        cnt <= W'(GAP_CYCLES);
      end else if (cnt != '0) begin
        cnt     <= cnt - 1'b1;
        expired <= (cnt == W'(1));
      end
    end
  end

endmodule

// File: rtl/cmd_sequencer.sv
// Replays the AT commands stored in the command memory into the UART TX FIFO,
// with a programmable idle gap between commands.
module cmd_sequencer
  import cmd_pkg::*;
#(
  parameter int CMD_WIDTH  = 32,
  parameter int CMD_DEPTH  = 16,
  parameter int GAP_CYCLES = 50000,
  parameter int ADDR_W     = $clog2(CMD_DEPTH * CMD_WIDTH + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         abort,
  input  logic                         loop,
  input  logic                         programming,
  output logic                         mem_rd_en,
  output logic [ADDR_W-1:0]            mem_addr,
  input  logic [7:0]                   mem_rdata,
  input  logic                         tx_ready,
  output logic                         tx_valid,
  output logic [7:0]                   tx_data,
  output logic                         busy,
  output logic [$clog2(CMD_DEPTH)-1:0] cur_cmd,
  output logic                         done,
  output logic [1:0]                   err_code,
  output logic                         err_pulse
);

  // cmd/num need one extra bit so a count of exactly CMD_DEPTH is representable.
  localparam int CMD_W  = $clog2(CMD_DEPTH + 1);
  localparam int BYTE_W = $clog2(CMD_WIDTH);
  localparam int CUR_W  = $clog2(CMD_DEPTH);

  seq_state_t        state;
  logic [CMD_W-1:0]  num;
  logic [CMD_W-1:0]  cmd;
  logic [BYTE_W-1:0] byte_idx;
  logic              gap_load;
  logic              gap_expired;
  logic              stop;

  function automatic logic [ADDR_W-1:0] byte_addr(input logic [CMD_W-1:0]  c,
                                                  input logic [BYTE_W-1:0] b);
    return ADDR_W'(32'd1 + 32'(c) * 32'(CMD_WIDTH) + 32'(b));
  endfunction

  // Programming the memory mid-run is treated exactly like an abort.
  assign stop = abort | programming;

  gap_timer #(
    .GAP_CYCLES(GAP_CYCLES)
  ) u_gap_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (gap_load),
    .expired(gap_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      num       <= '0;
      cmd       <= '0;
      byte_idx  <= '0;
      tx_data   <= '0;
      err_code  <= '0;
      err_pulse <= 1'b0;
      gap_load  <= 1'b0;
    end else begin
      err_pulse <= 1'b0;
      gap_load  <= 1'b0;
      if (state != IDLE && stop) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: if (start && !stop) state <= RD_NUM;
          RD_NUM: state <= WAIT_NUM;
          WAIT_NUM: begin
            cmd      <= '0;
            byte_idx <= '0;
            if (mem_rdata == 8'd0) begin
              err_code  <= ERR_EMPTY;
              err_pulse <= 1'b1;
              state     <= IDLE;
            end else begin
              if (mem_rdata > 8'(CMD_DEPTH)) begin
                num       <= CMD_W'(CMD_DEPTH);
                err_code  <= ERR_CLAMP;
                err_pulse <= 1'b1;
              end else begin
                num <= CMD_W'(mem_rdata);
              end
              state <= RD_BYTE;
            end
          end
          RD_BYTE: state <= WAIT_BYTE;
          WAIT_BYTE: begin
            tx_data <= mem_rdata;
            if (mem_rdata == PAD) begin
              state    <= GAP;
              gap_load <= 1'b1;
            end else begin
              state <= SEND;
            end
          end
          SEND: begin
            if (tx_ready) begin
              if (tx_data == LF || byte_idx == BYTE_W'(CMD_WIDTH - 1)) begin
                state    <= GAP;
                gap_load <= 1'b1;
              end else begin
                byte_idx <= byte_idx + 1'b1;
                state    <= RD_BYTE;
              end
            end
          end
          GAP: begin
            // gap_load still high means the timer has not been reloaded yet.
            if (gap_expired && !gap_load) begin
              byte_idx <= '0;
              if (cmd + 1'b1 == num) begin
                state <= DONE;
              end else begin
                cmd   <= cmd + 1'b1;
                state <= RD_BYTE;
              end
            end
          end
          DONE: state <= loop ? RD_NUM : IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign busy      = (state != IDLE);
  assign cur_cmd   = cmd[CUR_W-1:0];
  assign mem_rd_en = (state == RD_NUM) || (state == RD_BYTE);
  assign mem_addr  = (state == RD_BYTE) ? byte_addr(cmd, byte_idx) : '0;
  assign tx_valid  = (state == SEND) && tx_ready && !stop && !rst;
  assign done      = (state == DONE) && !stop;

endmodule

// File: tb/tb_cmd_sequencer.sv
// Scoreboard bench for cmd_sequencer: a 1-cycle memory model feeds it and pushed bytes are checked in order.
module tb_cmd_sequencer;
  import cmd_pkg::*;

  localparam int CW = 32;
  localparam int CD = 16;
  localparam int GC = 10;
  localparam int AW = $clog2(CD * CW + 1);

  logic          clk = 1'b0;
  logic          rst, start, abort, loop, programming, tx_ready;
  logic          mem_rd_en, tx_valid, busy, done, err_pulse;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_rdata, tx_data;
  logic [3:0]    cur_cmd;
  logic [1:0]    err_code;

  logic [7:0] mem [0:1023];
  logic [7:0] exp_q [$];
  int         push_t [$];
  int checks = 0, errors = 0;
  int cyc = 0, n_done = 0, n_err = 0, n_rd0 = 0, n_rd_hi = 0, max_cmd = 0;
  logic [1:0] last_err = 2'b00;
  logic prev_rd = 1'b0;

  cmd_sequencer #(.CMD_WIDTH(CW), .CMD_DEPTH(CD), .GAP_CYCLES(GC)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .loop(loop),
    .programming(programming), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .tx_ready(tx_ready), .tx_valid(tx_valid),
    .tx_data(tx_data), .busy(busy), .cur_cmd(cur_cmd), .done(done),
    .err_code(err_code), .err_pulse(err_pulse)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_rd_en) mem_rdata <= mem[mem_addr];
  end

  // Monitor: pops expected bytes whenever the DUT pushes, and tracks side events.
  always @(negedge clk) begin
    if (!rst) begin
      if (tx_valid) begin
        checks++;
        if (!tx_ready) begin
          errors++;
          $display("FAIL tx_valid_without_ready: tx_valid=1 tx_ready=0");
        end
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL tx_unexpected: pushed %h, nothing expected", tx_data);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (tx_data !== e) begin
            errors++;
            $display("FAIL tx_byte: got %h expected %h", tx_data, e);
          end
          push_t.push_back(cyc);
        end
      end
      if (mem_rd_en) begin
        checks++;
        if (prev_rd) begin
          errors++;
          $display("FAIL rd_back_to_back: mem_rd_en=1 two cycles in a row");
        end
        if (mem_addr == '0) n_rd0++;
        if (mem_addr >= AW'(33)) n_rd_hi++;
      end
      if (done) n_done++;
      if (err_pulse) begin
        n_err++;
        last_err = err_code;
      end
      if (busy && int'(cur_cmd) > max_cmd) max_cmd = int'(cur_cmd);
    end
    prev_rd = mem_rd_en;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
  endtask

  task automatic load_str(input int slot, input int idx, input string s);
    for (int i = 0; i < s.len(); i++) mem[1 + slot * CW + idx + i] = s[i];
  endtask

  task automatic exp_str(input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    bit got;
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    chk(name, got, 1);
  endtask

  task automatic wait_push(input int target, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (push_t.size() >= target) break;
    end
    chk("push_reached", push_t.size() >= target, 1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_tx_valid"}, tx_valid, 0);
    chk({tag, "_tx_data"}, tx_data, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err_code"}, err_code, 0);
    chk({tag, "_err_pulse"}, err_pulse, 0);
    chk({tag, "_mem_rd_en"}, mem_rd_en, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_cur_cmd"}, cur_cmd, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int bd, bp, br, be, gap;
    bit seen;
    rst = 1'b1; start = 1'b0; abort = 1'b0; loop = 1'b0;
    programming = 1'b0; tx_ready = 1'b1;
    clear_mem();
    idle(3);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1 rst = 1'b0;

    // Two commands: "AT\r\n" and "AT+X=1\r\n".
    mem[0] = 8'd2;
    load_str(0, 0, "AT");     mem[3] = 8'h0D;  mem[4] = 8'h0A;
    load_str(1, 0, "AT+X=1"); mem[39] = 8'h0D; mem[40] = 8'h0A;
    exp_str("AT"); exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
    exp_str("AT+X=1"); exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
    bd = n_done; bp = push_t.size();
    pulse_start();
    wait_done("two_cmd_done", 400);
    idle(3); @(negedge clk);
    chk("two_cmd_bytes", push_t.size() - bp, 12);
    chk("two_cmd_done_count", n_done - bd, 1);
    chk("two_cmd_busy_after", busy, 0);
    gap = (push_t.size() >= bp + 5) ? push_t[bp + 4] - push_t[bp + 3] : 0;
    chk("two_cmd_gap_ge_10", gap >= GC + 1, 1);

    // Empty memory.
    mem[0] = 8'd0;
    bd = n_done; bp = push_t.size();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (err_pulse) begin
        seen = 1'b1;
        break;
      end
    end
    chk("empty_err_pulse", seen, 1);
    chk("empty_err_code", err_code, ERR_EMPTY);
    chk("empty_busy", busy, 0);
    idle(5);
    chk("empty_no_done", n_done - bd, 0);
    chk("empty_no_push", push_t.size() - bp, 0);

    // Count 20 clamps to 16; each slot is one letter plus LF.
    clear_mem();
    mem[0] = 8'd20;
    for (int i = 0; i < CD; i++) begin
      mem[1 + i * CW]     = 8'h61 + 8'(i);
      mem[1 + i * CW + 1] = LF;
      exp_q.push_back(8'h61 + 8'(i));
      exp_q.push_back(LF);
    end
    bd = n_done; bp = push_t.size(); be = n_err; max_cmd = 0;
    pulse_start();
    wait_done("clamp_done", 2000);
    idle(2);
    chk("clamp_err_count", n_err - be, 1);
    chk("clamp_err_code", last_err, ERR_CLAMP);
    chk("clamp_bytes", push_t.size() - bp, 32);
    chk("clamp_max_cur_cmd", max_cmd, 15);
    chk("clamp_done_count", n_done - bd, 1);

    // Full 32-byte command without LF; slot 1 must never be read.
    clear_mem();
    mem[0] = 8'd1;
    for (int i = 0; i < CW; i++) begin
      mem[1 + i] = 8'h41 + 8'(i % 26);
      exp_q.push_back(8'h41 + 8'(i % 26));
    end
    mem[33] = 8'h5A;
    bp = push_t.size(); br = n_rd_hi;
    pulse_start();
    wait_done("full_done", 400);
    idle(2);
    chk("full_bytes", push_t.size() - bp, 32);
    chk("full_no_slot1_read", n_rd_hi - br, 0);

    // Stall for 50 cycles mid-command, then resume.
    clear_mem();
    mem[0] = 8'd1;
    load_str(0, 0, "HELLO"); mem[6] = LF;
    exp_str("HELLO"); exp_q.push_back(LF);
    bp = push_t.size();
    pulse_start();
    wait_push(bp + 2, 100);
    #1 tx_ready = 1'b0;
    idle(50);
    chk("stall_no_push", push_t.size() - bp, 2);
    #1 tx_ready = 1'b1;
    wait_done("stall_done", 200);
    idle(2);
    chk("stall_bytes", push_t.size() - bp, 6);
    chk("stall_queue_empty", exp_q.size(), 0);

    // Abort during a stall; ready rises in the same cycle but nothing may be pushed.
    exp_str("HE");
    bd = n_done; bp = push_t.size();
    pulse_start();
    wait_push(bp + 2, 100);
    #1 tx_ready = 1'b0;
    idle(10);
    #1 abort = 1'b1; tx_ready = 1'b1;
    @(negedge clk);
    chk("abort_tx_valid", tx_valid, 0);
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    idle(20);
    chk("abort_bytes", push_t.size() - bp, 2);
    chk("abort_no_done", n_done - bd, 0);

    // start while programming, and start together with abort, are ignored.
    programming = 1'b1;
    pulse_start();
    @(negedge clk);
    chk("prog_start_busy", busy, 0);
    #1 programming = 1'b0;
    @(posedge clk); #1 start = 1'b1; abort = 1'b1;
    @(posedge clk); #1 start = 1'b0; abort = 1'b0;
    @(negedge clk);
    chk("abort_start_busy", busy, 0);

    // Loop over a padded "OK" command; drop loop after the second done.
    clear_mem();
    mem[0] = 8'd1;
    load_str(0, 0, "OK");
    exp_str("OKOKOK");
    bd = n_done; br = n_rd0; bp = push_t.size();
    loop = 1'b1;
    pulse_start();
    wait_done("loop_done1", 200);
    wait_done("loop_done2", 200);
    @(posedge clk); #1 loop = 1'b0;
    wait_done("loop_done3", 200);
    idle(5); @(negedge clk);
    chk("loop_busy_after", busy, 0);
    chk("loop_done_count", n_done - bd, 3);
    chk("loop_rd0_count", n_rd0 - br, 3);
    chk("loop_bytes", push_t.size() - bp, 6);

    // Reset while stalled in SEND.
    clear_mem();
    mem[0] = 8'd1;
    load_str(0, 0, "HELLO"); mem[6] = LF;
    #1 tx_ready = 1'b0;
    pulse_start();
    idle(8);
    #1 rst = 1'b1; tx_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_all_zero("midrst");
    @(posedge clk); #1 rst = 1'b0;
    idle(3);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
